// File: rtl/ofmap_accumulator.sv
// Output-feature-map accumulator: adds de-skewed array partial sums into the ofmap buffer
// through a read-add-write pipeline, walking pixel, then channel group, then pass.
module ofmap_accumulator #(
    parameter int MAC_COL           = 16,
    parameter int OFMAP_BITWIDTH    = 32,
    parameter int OFMAP_ADDR_BIT    = 10,
    parameter int OFMAP_CHANNEL_NUM = 64,
    parameter int IFMAP_CHANNEL_NUM = 32,
    parameter int MAC_ROW           = 16,
    parameter int WEIGHT_WIDTH      = 3,
    parameter int WEIGHT_HEIGHT     = 3,
    parameter int OFMAP_WIDTH       = 14,
    parameter int OFMAP_HEIGHT      = 14
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start_in,
    input  logic                                psum_valid_in,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   psum_in,
    output logic                                ofmap_read_en_out,
    output logic [OFMAP_ADDR_BIT-1:0]           ofmap_rd_addr_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_rdata_in,
    output logic                                ofmap_write_en_out,
    output logic [OFMAP_ADDR_BIT-1:0]           ofmap_wr_addr_out,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_wdata_out,
    output logic                                busy_out,
    output logic                                layer_done_out
);

    localparam int PIX    = OFMAP_WIDTH * OFMAP_HEIGHT;
    localparam int GRP    = OFMAP_CHANNEL_NUM / MAC_COL;
    localparam int PASS   = (IFMAP_CHANNEL_NUM / MAC_ROW) * WEIGHT_WIDTH * WEIGHT_HEIGHT;
    localparam int DW     = MAC_COL * OFMAP_BITWIDTH;
    localparam int PIX_W  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int GRP_W  = (GRP > 1) ? $clog2(GRP) : 1;
    localparam int PASS_W = (PASS > 1) ? $clog2(PASS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [PIX_W-1:0]          pixel_r;
    logic [GRP_W-1:0]          group_r;
    logic [PASS_W-1:0]         pass_r;
    logic                      accept_s, pix_last_s, grp_last_s, pass_last_s, beat_last_s;
    logic [OFMAP_ADDR_BIT-1:0] beat_addr_s;

    logic                      s1_valid_r, s1_first_r, s1_last_r;
    logic [DW-1:0]             s1_psum_r;
    logic [OFMAP_ADDR_BIT-1:0] s1_addr_r;
    logic [DW-1:0]             sum_s;

    logic                      wr_en_r, wr_last_r;
    logic [OFMAP_ADDR_BIT-1:0] wr_addr_r;
    logic [DW-1:0]             wr_data_r;

    // Lane-wise modulo add; the first pass stores the partial sum unchanged.
    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] psum,
                                               input logic [DW-1:0] old,
                                               input logic          first);
        logic [DW-1:0] res;
        res = '0;
        for (int c = 0; c < MAC_COL; c++) begin
            if (first) begin
                res[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] = psum[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
            end else begin
                res[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] = psum[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH]
                                                        + old[c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
            end
        end
        return res;
    endfunction

    assign accept_s    = (state_r == RUN) && psum_valid_in;
    assign pix_last_s  = (pixel_r == PIX_W'(PIX - 1));
    assign grp_last_s  = (group_r == GRP_W'(GRP - 1));
    assign pass_last_s = (pass_r == PASS_W'(PASS - 1));
    assign beat_last_s = pix_last_s && grp_last_s && pass_last_s;
    assign beat_addr_s = OFMAP_ADDR_BIT'(group_r) * OFMAP_ADDR_BIT'(PIX) + OFMAP_ADDR_BIT'(pixel_r);

    // Stage 0 read is combinational so rdata lines up with stage 1 on the next cycle.
    assign ofmap_read_en_out = accept_s && (pass_r != PASS_W'(0));
    assign ofmap_rd_addr_out = ofmap_read_en_out ? beat_addr_s : '0;
    assign sum_s             = lane_add(s1_psum_r, ofmap_rdata_in, s1_first_r);

    assign ofmap_write_en_out = wr_en_r;
    assign ofmap_wr_addr_out  = wr_addr_r;
    assign ofmap_wdata_out    = wr_data_r;
    assign busy_out           = (state_r == RUN) || (state_r == DRAIN);
    assign layer_done_out     = (state_r == DONE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DRAIN waits for the write tagged as the layer's final beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (accept_s && beat_last_s) state_nxt_s = DRAIN;
                else                         state_nxt_s = RUN;
            end
            DRAIN: begin
                if (wr_en_r && wr_last_r) state_nxt_s = DONE;
                else                      state_nxt_s = DRAIN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pixel / group / pass counters: cleared on layer start, advanced per accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pixel_r <= '0;
            group_r <= '0;
            pass_r  <= '0;
        end else if ((state_r == IDLE) && start_in) begin
            pixel_r <= '0;
            group_r <= '0;
            pass_r  <= '0;
        end else if (accept_s) begin
            if (pix_last_s) begin
                pixel_r <= '0;
                if (grp_last_s) begin
                    group_r <= '0;
                    pass_r  <= pass_last_s ? '0 : pass_r + PASS_W'(1);
                end else begin
                    group_r <= group_r + GRP_W'(1);
                end
            end else begin
                pixel_r <= pixel_r + PIX_W'(1);
            end
        end
    end

    // Stage 1 capture of the accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_psum_r  <= '0;
            s1_addr_r  <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_first_r <= (pass_r == PASS_W'(0));
                s1_last_r  <= beat_last_s;
                s1_psum_r  <= psum_in;
                s1_addr_r  <= beat_addr_s;
            end
        end
    end

    // Stage 2 registered write port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_r   <= 1'b0;
            wr_last_r <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            wr_en_r <= s1_valid_r;
            if (s1_valid_r) begin
                wr_last_r <= s1_last_r;
                wr_addr_r <= s1_addr_r;
                wr_data_r <= sum_s;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_accumulator.sv
// Randomized bench for ofmap_accumulator with a buffer model and a per-beat scoreboard
// derived from flat beat numbering (address = n mod GRP*PIX, pass = n div GRP*PIX).
module tb_ofmap_accumulator;

    localparam int COLS = 4;
    localparam int BW   = 32;
    localparam int AW   = 10;
    localparam int DW   = COLS * BW;
    localparam int GP   = 8;            // GRP*PIX with the parameters below
    localparam int NB   = 16;           // GP * PASS
    localparam int BIG  = 32'h3fffffff;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_in = 1'b0;
    logic          psum_valid_in = 1'b0;
    logic [DW-1:0] psum_in = '0;
    logic          ofmap_read_en_out;
    logic [AW-1:0] ofmap_rd_addr_out;
    logic [DW-1:0] ofmap_rdata_in = '0;
    logic          ofmap_write_en_out;
    logic [AW-1:0] ofmap_wr_addr_out;
    logic [DW-1:0] ofmap_wdata_out;
    logic          busy_out;
    logic          layer_done_out;

    ofmap_accumulator #(
        .MAC_COL(COLS), .OFMAP_BITWIDTH(BW), .OFMAP_ADDR_BIT(AW),
        .OFMAP_CHANNEL_NUM(8), .IFMAP_CHANNEL_NUM(2), .MAC_ROW(1),
        .WEIGHT_WIDTH(1), .WEIGHT_HEIGHT(1), .OFMAP_WIDTH(2), .OFMAP_HEIGHT(2)
    ) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in), .psum_valid_in(psum_valid_in),
        .psum_in(psum_in), .ofmap_read_en_out(ofmap_read_en_out),
        .ofmap_rd_addr_out(ofmap_rd_addr_out), .ofmap_rdata_in(ofmap_rdata_in),
        .ofmap_write_en_out(ofmap_write_en_out), .ofmap_wr_addr_out(ofmap_wr_addr_out),
        .ofmap_wdata_out(ofmap_wdata_out), .busy_out(busy_out), .layer_done_out(layer_done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    wr_t           wq[$];
    wr_t           e_w;
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] exp_mem [0:GP-1];
    logic          exp_rd = 1'b0;
    logic [AW-1:0] exp_rd_addr = '0;
    int            exp_done_cyc = -1;
    int            busy_from = BIG;
    int            busy_end = BIG;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ofmap buffer with one-cycle read latency.
    always @(posedge clk) begin
        if (ofmap_read_en_out) ofmap_rdata_in <= mem[ofmap_rd_addr_out];
        if (ofmap_write_en_out) mem[ofmap_wr_addr_out] <= ofmap_wdata_out;
    end

    // Per-cycle monitor against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            check_eq("wr_en", DW'(ofmap_write_en_out), DW'((wq.size() > 0) && (wq[0].cyc == cyc)));
            if ((wq.size() > 0) && (wq[0].cyc == cyc)) begin
                e_w = wq.pop_front();
                if (ofmap_write_en_out) begin
                    check_eq("wr_addr", DW'(ofmap_wr_addr_out), DW'(e_w.addr));
                    check_eq("wr_data", ofmap_wdata_out, e_w.data);
                end
            end
            check_eq("rd_en", DW'(ofmap_read_en_out), DW'(exp_rd));
            if (exp_rd) check_eq("rd_addr", DW'(ofmap_rd_addr_out), DW'(exp_rd_addr));
            check_eq("done", DW'(layer_done_out), DW'(cyc == exp_done_cyc));
            check_eq("busy", DW'(busy_out), DW'((cyc >= busy_from) && (cyc < busy_end)));
        end
    end

    function automatic logic [DW-1:0] make_beat(input int mode, input int n);
        logic [DW-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            case (mode)
                0:       v[c*BW +: BW] = 32'(n + c);
                1:       v[c*BW +: BW] = $urandom;
                default: v[c*BW +: BW] = (n < GP) ? 32'hFFFF_FFFF : 32'h0000_0002;
            endcase
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input int gap_lo, input int gap_hi, input int mode,
                             input bit poke, input int stop_after);
        int            a, p, gap;
        logic [DW-1:0] d, e;
        // valid while IDLE must be ignored
        exp_rd = 1'b0;
        psum_valid_in = 1'b1;
        psum_in = make_beat(1, 0);
        repeat (2) step();
        psum_valid_in = 1'b0;
        start_in = 1'b1;
        busy_end = BIG;
        busy_from = cyc + 1;
        step();
        start_in = 1'b0;
        for (int n = 0; n < NB; n++) begin
            if (n == stop_after) return;
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
                psum_valid_in = 1'b0;
                psum_in = make_beat(1, 0);
                exp_rd = 1'b0;
                start_in = poke && ($urandom_range(3, 0) == 0);
                step();
            end
            d = make_beat(mode, n);
            a = n % GP;
            p = n / GP;
            e = '0;
            for (int c = 0; c < COLS; c++) begin
                e[c*BW +: BW] = (p == 0) ? d[c*BW +: BW] : exp_mem[a][c*BW +: BW] + d[c*BW +: BW];
            end
            exp_mem[a] = e;
            psum_valid_in = 1'b1;
            psum_in = d;
            start_in = poke && ($urandom_range(3, 0) == 0);
            exp_rd = (p != 0);
            exp_rd_addr = AW'(a);
            wq.push_back('{cyc + 2, AW'(a), e});
            if (n == NB - 1) begin
                exp_done_cyc = cyc + 3;
                busy_end = cyc + 3;
            end
            step();
        end
        // keep valid high through DRAIN, DONE and back into IDLE
        start_in = 1'b0;
        exp_rd = 1'b0;
        psum_valid_in = 1'b1;
        repeat (5) step();
        psum_valid_in = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rd_en"}, DW'(ofmap_read_en_out), '0);
        check_eq({tag, "_rd_addr"}, DW'(ofmap_rd_addr_out), '0);
        check_eq({tag, "_wr_en"}, DW'(ofmap_write_en_out), '0);
        check_eq({tag, "_wr_addr"}, DW'(ofmap_wr_addr_out), '0);
        check_eq({tag, "_wdata"}, ofmap_wdata_out, '0);
        check_eq({tag, "_busy"}, DW'(busy_out), '0);
        check_eq({tag, "_done"}, DW'(layer_done_out), '0);
    endtask

    task automatic check_ramp_memory(input string tag);
        logic [DW-1:0] w;
        for (int k = 0; k < GP; k++) begin
            for (int c = 0; c < COLS; c++) w[c*BW +: BW] = 32'((k + c) + (k + GP + c));
            check_eq(tag, mem[k], w);
        end
    endtask

    task automatic check_model_memory(input string tag);
        for (int k = 0; k < GP; k++) check_eq(tag, mem[k], exp_mem[k]);
    endtask

    initial begin
        logic [DW-1:0] w0;
        #3;
        check_outputs_zero("reset");
        repeat (2) step();
        rstn = 1'b1;

        run_layer(0, 0, 0, 1'b0, -1);
        check_ramp_memory("final_b2b");

        run_layer(2, 2, 0, 1'b0, -1);
        check_ramp_memory("final_gap");

        run_layer(0, 1, 2, 1'b0, -1);
        w0 = mem[0];
        check_eq("wrap_lane0", DW'(w0[BW-1:0]), DW'(32'h0000_0001));
        check_model_memory("final_wrap");

        run_layer(0, 2, 1, 1'b1, -1);
        check_model_memory("final_rand");

        // reset mid-layer after five beats
        run_layer(0, 0, 1, 1'b0, 5);
        rstn = 1'b0;
        psum_valid_in = 1'b1;
        #1;
        check_outputs_zero("midrst");
        wq.delete();
        exp_rd = 1'b0;
        exp_done_cyc = -1;
        busy_from = BIG;
        busy_end = BIG;
        repeat (2) step();
        rstn = 1'b1;
        repeat (6) step();
        psum_valid_in = 1'b0;

        run_layer(0, 1, 1, 1'b1, -1);
        check_model_memory("final_restart");

        repeat (3) step();
        check_eq("wq_empty", DW'(wq.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofmap_accumulator.md
OFMAP_ACCUMULATOR -- requirements
Module: ofmap_accumulator

Interface
REQ-001 Parameters (name, default, meaning): MAC_COL 16 array columns; OFMAP_BITWIDTH 32 psum/ofmap word width; OFMAP_ADDR_BIT 10 ofmap buffer address width; OFMAP_CHANNEL_NUM 64; IFMAP_CHANNEL_NUM 32; MAC_ROW 16; WEIGHT_WIDTH 3; WEIGHT_HEIGHT 3; OFMAP_WIDTH 14; OFMAP_HEIGHT 14.
REQ-002 Derived constants: PIX = OFMAP_WIDTH*OFMAP_HEIGHT (196); GRP = OFMAP_CHANNEL_NUM/MAC_COL (4); PASS = (IFMAP_CHANNEL_NUM/MAC_ROW)*WEIGHT_WIDTH*WEIGHT_HEIGHT (18); GRP*PIX SHALL fit in OFMAP_ADDR_BIT.
REQ-003 Ports (name direction width meaning): clk in 1 single clock; rstn in 1 asynchronous active-low reset.
REQ-004 start_in in 1 one-cycle pulse beginning a layer.
REQ-005 psum_valid_in in 1 one row of de-skewed array outputs present this cycle.
REQ-006 psum_in in MAC_COL*OFMAP_BITWIDTH; lane c at bits [c*OFMAP_BITWIDTH +: OFMAP_BITWIDTH].
REQ-007 ofmap_read_en_out out 1; ofmap_rd_addr_out out OFMAP_ADDR_BIT; ofmap_rdata_in in MAC_COL*OFMAP_BITWIDTH, valid exactly 1 cycle after read_en.
REQ-008 ofmap_write_en_out out 1; ofmap_wr_addr_out out OFMAP_ADDR_BIT; ofmap_wdata_out out MAC_COL*OFMAP_BITWIDTH.
REQ-009 busy_out out 1 high from RUN entry to DONE; layer_done_out out 1 one-cycle completion pulse.

Function
REQ-010 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_in; RUN->DRAIN when the final beat (pixel PIX-1, group GRP-1, pass PASS-1) is accepted; DRAIN->DONE after that beat's write issues; DONE->IDLE next cycle.
REQ-011 On IDLE->RUN, pixel, group and pass counters SHALL clear to 0.
REQ-012 A beat is accepted only when psum_valid_in=1 in RUN; psum_valid_in in IDLE, DRAIN or DONE SHALL be ignored with no buffer access.
REQ-013 Counter order: pixel innermost (0..PIX-1), wraps to 0 and advances group; group (0..GRP-1) wraps and advances pass (0..PASS-1).
REQ-014 Beat address = group*PIX + pixel, computed at acceptance.
REQ-015 Stage 0 (acceptance cycle): if pass!=0, ofmap_read_en_out=1 combinationally with ofmap_rd_addr_out=beat address; if pass=0 no read.
REQ-016 Stage 1 (next cycle): register psum, address, first-pass flag; sum per lane = psum lane + rdata lane (pass!=0) or psum lane (pass=0), modulo 2^OFMAP_BITWIDTH, no saturation.
REQ-017 Stage 2: ofmap_write_en_out, ofmap_wr_addr_out, ofmap_wdata_out registered, asserted exactly 2 cycles after acceptance, one write per accepted beat.
REQ-018 Back-to-back beats every cycle SHALL be sustained; no stall or backpressure output exists.
REQ-019 No read-after-write hazard handling; same address recurs only after GRP*PIX beats.
REQ-020 start_in outside IDLE SHALL be ignored.
REQ-021 layer_done_out pulses in DONE, 1 cycle after the final write; busy_out low in IDLE and DONE.

Reset
REQ-022 rstn=0 asynchronously forces IDLE, all counters 0, all pipeline valids 0.
REQ-023 During reset all outputs 0: read_en, write_en, addresses, wdata, busy_out, layer_done_out.
REQ-024 Reset mid-layer discards in-flight beats; no write issues after rstn deasserts until a new start_in and beat.

Verification
REQ-025 Params PIX=4, GRP=2, PASS=2; start_in then 16 consecutive beats, lane c of beat n = n+c, memory model with 1-cycle read -> addr k holds (k+c)+(k+8+c) per lane, layer_done_out 1 cycle after last write, 16 writes total.
REQ-026 First pass only: first 8 beats -> no read_en asserted, write data equals psum exactly, write at acceptance+2.
REQ-027 Wrap: lane psum 0xFFFFFFFF on pass 0, 0x00000002 on pass 1 -> stored 0x00000001.
REQ-028 Gapped valid (1 beat every 3 cycles) -> identical final memory to back-to-back run; psum_valid_in during IDLE/DONE -> no read or write.
REQ-029 rstn low after 5 beats -> all outputs 0 same cycle; new start_in restarts at address 0, pass 0 (no read).
REQ-030 start_in pulsed during RUN -> counters unchanged, sequence completes normally.
